// File: rtl/sensor_scan_adc.sv
// sensor_scan_adc: round-robin scanner for four sensor channels. For each
// channel it selects the external analog mux, waits for the mux to settle,
// reads one 8-bit sample from a serial ADC (SPI mode 0, MSB first), then
// presents the reading with its channel index and a one-cycle valid strobe.
// Build option: define SENSOR_SCAN_CHAN_MASK_EN to add chan_mask[3:0], which
// restricts the scan to the channels whose mask bit is set.
module sensor_scan_adc #(
    parameter int CLK_DIV = 2,
    parameter int SETTLE  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
`ifdef SENSOR_SCAN_CHAN_MASK_EN
    input  logic [3:0] chan_mask,
`endif
    input  logic       adc_miso,
    output logic       adc_sclk,
    output logic       adc_cs_n,
    output logic [1:0] adc_ch,
    output logic [7:0] data_out,
    output logic [1:0] chan_out,
    output logic       sample_valid,
    output logic       busy
);

    // One counter serves both the settle wait and the sclk divider.
    localparam int CNT_MAX = (SETTLE > CLK_DIV) ? SETTLE : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       tog_q;
    logic [7:0]       shift_q;
    logic [1:0]       chan_q;
    logic             sclk_q;
    logic             cs_n_q;
    logic [1:0]       adc_ch_q;
    logic [7:0]       data_out_q;
    logic [1:0]       chan_out_q;
    logic             sample_valid_q;
    logic             busy_q;

    logic [3:0]       mask_w;
    logic [2:0]       idle_pick_d;
    logic [2:0]       next_pick_d;

`ifdef SENSOR_SCAN_CHAN_MASK_EN
    assign mask_w = chan_mask;
`else
    assign mask_w = 4'b1111;
`endif

    // Returns {found, index} of the first enabled channel at or after start,
    // searching round-robin. When nothing is enabled, index is start.
    function automatic logic [2:0] pick_chan(input logic [3:0] mask,
                                             input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] c;
        res = {1'b0, start};
        for (int k = 3; k >= 0; k--) begin
            c = start + 2'(k);
            if (mask[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    // Channel choice when leaving IDLE (retained index) and after a LATCH.
    assign idle_pick_d = pick_chan(mask_w, chan_q);
    assign next_pick_d = pick_chan(mask_w, chan_q + 2'd1);

    // Scan FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            tog_q          <= '0;
            shift_q        <= '0;
            chan_q         <= '0;
            sclk_q         <= 1'b0;
            cs_n_q         <= 1'b1;
            adc_ch_q       <= '0;
            data_out_q     <= '0;
            chan_out_q     <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= 1'b0;
                    cs_n_q <= 1'b1;
                    if (enable && idle_pick_d[2]) begin
                        chan_q   <= idle_pick_d[1:0];
                        adc_ch_q <= idle_pick_d[1:0];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        tog_q   <= '0;
                        sclk_q  <= 1'b0;
                        cs_n_q  <= 1'b0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        tog_q  <= tog_q + 4'd1;
                        // Capture on the low-to-high sclk transition.
                        if (!sclk_q) begin
                            shift_q <= {shift_q[6:0], adc_miso};
                        end
                        // Sixteenth toggle is the falling edge after bit 0.
                        if (tog_q == 4'd15) begin
                            cs_n_q  <= 1'b1;
                            state_q <= ST_LATCH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_LATCH: begin
                    data_out_q     <= shift_q;
                    chan_out_q     <= chan_q;
                    sample_valid_q <= 1'b1;
                    chan_q         <= next_pick_d[1:0];
                    if (enable && next_pick_d[2]) begin
                        adc_ch_q <= next_pick_d[1:0];
                        cnt_q    <= '0;
                        state_q  <= ST_SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_sclk     = sclk_q;
    assign adc_cs_n     = cs_n_q;
    assign adc_ch       = adc_ch_q;
    assign data_out     = data_out_q;
    assign chan_out     = chan_out_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sensor_scan_adc.sv
// Testbench for sensor_scan_adc: two instances (default parameters and
// CLK_DIV=1/SETTLE=1), each with a behavioural SPI mode-0 ADC, plus
// scoreboards keyed on expected data, channel and arrival cycle.
module tb_sensor_scan_adc;

    typedef struct {
        logic [7:0] data;
        logic [1:0] chan;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       enable_f = 1'b0;
`ifdef SENSOR_SCAN_CHAN_MASK_EN
    logic [3:0] chan_mask = 4'hF;
`endif

    logic       adc_miso = 1'b0, adc_sclk, adc_cs_n;
    logic [1:0] adc_ch, chan_out;
    logic [7:0] data_out;
    logic       sample_valid, busy;

    logic       adc_miso_f = 1'b0, adc_sclk_f, adc_cs_n_f;
    logic [1:0] adc_ch_f, chan_out_f;
    logic [7:0] data_out_f;
    logic       sample_valid_f, busy_f;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_m[$];
    exp_t q_f[$];
    logic [7:0] adc_mem [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sensor_scan_adc dut (
        .clk(clk), .reset(reset), .enable(enable),
`ifdef SENSOR_SCAN_CHAN_MASK_EN
        .chan_mask(chan_mask),
`endif
        .adc_miso(adc_miso), .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n),
        .adc_ch(adc_ch), .data_out(data_out), .chan_out(chan_out),
        .sample_valid(sample_valid), .busy(busy)
    );

    sensor_scan_adc #(.CLK_DIV(1), .SETTLE(1)) dut_f (
        .clk(clk), .reset(reset), .enable(enable_f),
`ifdef SENSOR_SCAN_CHAN_MASK_EN
        .chan_mask(4'hF),
`endif
        .adc_miso(adc_miso_f), .adc_sclk(adc_sclk_f), .adc_cs_n(adc_cs_n_f),
        .adc_ch(adc_ch_f), .data_out(data_out_f), .chan_out(chan_out_f),
        .sample_valid(sample_valid_f), .busy(busy_f)
    );

    initial adc_mem = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

    // ADC model: MSB ready while cs_n is high, next bit after each sclk fall.
    int   bit_m, bit_f;
    logic prev_m = 1'b0, prev_f = 1'b0;
    always @(negedge clk) begin
        if (adc_cs_n === 1'b1) begin
            bit_m = 7;
            adc_miso = adc_mem[adc_ch][7];
        end else if (prev_m === 1'b1 && adc_sclk === 1'b0) begin
            bit_m = bit_m - 1;
            if (bit_m >= 0) adc_miso = adc_mem[adc_ch][bit_m];
        end
        prev_m = adc_sclk;
    end
    always @(negedge clk) begin
        if (adc_cs_n_f === 1'b1) begin
            bit_f = 7;
            adc_miso_f = adc_mem[adc_ch_f][7];
        end else if (prev_f === 1'b1 && adc_sclk_f === 1'b0) begin
            bit_f = bit_f - 1;
            if (bit_f >= 0) adc_miso_f = adc_mem[adc_ch_f][bit_f];
        end
        prev_f = adc_sclk_f;
    end

    // Scoreboard for the default instance.
    always @(negedge clk) begin
        exp_t e;
        if (sample_valid === 1'b1) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected_sample got chan=%0d data=%02h cyc=%0d, required no sample",
                         chan_out, data_out, cyc);
            end else begin
                e = q_m.pop_front();
                if (data_out !== e.data || chan_out !== e.chan || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL main_sample got chan=%0d data=%02h cyc=%0d, required chan=%0d data=%02h cyc=%0d",
                             chan_out, data_out, cyc, e.chan, e.data, e.cyc);
                end else begin
                    $display("sample main chan=%0d data=%02h cyc=%0d ok", chan_out, data_out, cyc);
                end
            end
        end
    end

    // Scoreboard for the fast instance.
    always @(negedge clk) begin
        exp_t e;
        if (sample_valid_f === 1'b1) begin
            checks++;
            if (q_f.size() == 0) begin
                errors++;
                $display("FAIL fast_unexpected_sample got chan=%0d data=%02h cyc=%0d, required no sample",
                         chan_out_f, data_out_f, cyc);
            end else begin
                e = q_f.pop_front();
                if (data_out_f !== e.data || chan_out_f !== e.chan || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL fast_sample got chan=%0d data=%02h cyc=%0d, required chan=%0d data=%02h cyc=%0d",
                             chan_out_f, data_out_f, cyc, e.chan, e.data, e.cyc);
                end else begin
                    $display("sample fast chan=%0d data=%02h cyc=%0d ok", chan_out_f, data_out_f, cyc);
                end
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input bit fast, input int budget);
        int n = 0;
        while ((fast ? q_f.size() : q_m.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((fast ? q_f.size() : q_m.size()) != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout got %0d pending samples, required 0",
                     fast ? "fast" : "main", fast ? q_f.size() : q_m.size());
            if (fast) q_f.delete(); else q_m.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 7;
        if (adc_sclk !== 1'b0)     begin errors++; $display("FAIL reset_sclk got %b required 0", adc_sclk); end
        if (adc_cs_n !== 1'b1)     begin errors++; $display("FAIL reset_cs_n got %b required 1", adc_cs_n); end
        if (adc_ch !== 2'd0)       begin errors++; $display("FAIL reset_adc_ch got %0d required 0", adc_ch); end
        if (data_out !== 8'h00)    begin errors++; $display("FAIL reset_data_out got %02h required 00", data_out); end
        if (chan_out !== 2'd0)     begin errors++; $display("FAIL reset_chan_out got %0d required 0", chan_out); end
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %b required 0", sample_valid); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        $display("test_reset done");
        reset = 1'b0;
    endtask

    task automatic test_scan();
        int c, low_cnt, rises, last_rise, sp_bad, ch_bad, idle_bad;
        logic prev_sclk, in_low;
        logic [1:0] ch_hold;
        @(negedge clk);
        c = cyc;
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            q_m.push_back('{adc_mem[k % 4], 2'(k % 4), c + 38 + 37 * k});
        end
        low_cnt = 0; rises = 0; last_rise = 0; sp_bad = 0; ch_bad = 0; idle_bad = 0;
        prev_sclk = 1'b0; in_low = 1'b0; ch_hold = 2'd3;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (adc_cs_n === 1'b0) begin
                if (!in_low) begin in_low = 1'b1; ch_hold = adc_ch; end
                low_cnt++;
                if (adc_ch !== ch_hold) ch_bad++;
                if (adc_sclk === 1'b1 && prev_sclk === 1'b0) begin
                    if (rises > 0 && cyc - last_rise != 4) sp_bad++;
                    last_rise = cyc;
                    rises++;
                end
            end else if (adc_sclk !== 1'b0) begin
                idle_bad++;
            end
            prev_sclk = adc_sclk;
        end
        checks += 6;
        if (low_cnt != 32)   begin errors++; $display("FAIL spi_cs_low_cycles got %0d required 32", low_cnt); end
        if (rises != 8)      begin errors++; $display("FAIL spi_sclk_rises got %0d required 8", rises); end
        if (sp_bad != 0)     begin errors++; $display("FAIL spi_rise_spacing got %0d bad gaps required 0", sp_bad); end
        if (ch_bad != 0)     begin errors++; $display("FAIL spi_adc_ch_stable got %0d changes required 0", ch_bad); end
        if (ch_hold !== 2'd0) begin errors++; $display("FAIL spi_adc_ch got %0d required 0", ch_hold); end
        if (idle_bad != 0)   begin errors++; $display("FAIL spi_sclk_idle got %0d high cycles required 0", idle_bad); end
        wait_until(c + 200);
        enable = 1'b0;
        wait_drain(1'b0, 400);
        $display("test_scan done");
    endtask

    task automatic test_enable_drop();
        int c, d;
        do_reset();
        @(negedge clk);
        c = cyc;
        enable = 1'b1;
        q_m.push_back('{8'hA5, 2'd0, c + 38});
        q_m.push_back('{8'h3C, 2'd1, c + 75});
        wait_until(c + 52);
        enable = 1'b0;
        wait_until(c + 76);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_after got %b required 0", busy); end
        wait_until(c + 95);
        checks += 2;
        if (busy !== 1'b0)     begin errors++; $display("FAIL drop_busy_idle got %b required 0", busy); end
        if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL drop_cs_n_idle got %b required 1", adc_cs_n); end
        d = cyc;
        enable = 1'b1;
        q_m.push_back('{8'hFF, 2'd2, d + 38});
        wait_until(d + 3);  enable = 1'b0;
        wait_until(d + 10); enable = 1'b1;
        wait_until(d + 12); enable = 1'b0;
        wait_drain(1'b0, 100);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_final got %b required 0", busy); end
        $display("test_enable_drop done");
    endtask

    task automatic test_reset_mid();
        int c, r;
        do_reset();
        @(negedge clk);
        c = cyc;
        enable = 1'b1;
        q_m.push_back('{8'hA5, 2'd0, c + 38});
        wait_until(c + 62);
        checks++;
        if (adc_cs_n !== 1'b0) begin errors++; $display("FAIL mid_cs_n_before got %b required 0", adc_cs_n); end
        reset = 1'b1;
        #1;
        checks += 5;
        if (adc_cs_n !== 1'b1)     begin errors++; $display("FAIL mid_reset_cs_n got %b required 1", adc_cs_n); end
        if (adc_sclk !== 1'b0)     begin errors++; $display("FAIL mid_reset_sclk got %b required 0", adc_sclk); end
        if (data_out !== 8'h00)    begin errors++; $display("FAIL mid_reset_data_out got %02h required 00", data_out); end
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b required 0", sample_valid); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL mid_reset_busy got %b required 0", busy); end
        wait_until(c + 65);
        reset = 1'b0;
        r = cyc;
        q_m.push_back('{8'hA5, 2'd0, r + 38});
        wait_until(r + 40);
        enable = 1'b0;
        wait_drain(1'b0, 100);
        $display("test_reset_mid done");
    endtask

    task automatic test_fast();
        int c;
        do_reset();
        @(negedge clk);
        c = cyc;
        enable_f = 1'b1;
        q_f.push_back('{8'hA5, 2'd0, c + 19});
        q_f.push_back('{8'h3C, 2'd1, c + 37});
        wait_until(c + 21);
        enable_f = 1'b0;
        wait_drain(1'b1, 100);
        $display("test_fast done");
    endtask

`ifdef SENSOR_SCAN_CHAN_MASK_EN
    task automatic test_mask();
        int c;
        chan_mask = 4'b1010;
        do_reset();
        @(negedge clk);
        c = cyc;
        enable = 1'b1;
        q_m.push_back('{8'h3C, 2'd1, c + 38});
        q_m.push_back('{8'h00, 2'd3, c + 75});
        q_m.push_back('{8'h3C, 2'd1, c + 112});
        q_m.push_back('{8'h00, 2'd3, c + 149});
        wait_until(c + 115);
        enable = 1'b0;
        wait_drain(1'b0, 200);
        chan_mask = 4'b0000;
        do_reset();
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin
                errors++;
                $display("FAIL mask_zero_idle got busy=%b cs_n=%b cyc=%0d required busy=0 cs_n=1",
                         busy, adc_cs_n, cyc);
            end
        end
        enable = 1'b0;
        chan_mask = 4'hF;
        $display("test_mask done");
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_enable_drop();
        test_reset_mid();
        test_fast();
`ifdef SENSOR_SCAN_CHAN_MASK_EN
        test_mask();
`endif
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no completion by cyc=%0d required finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
